// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter between the core and the loader.
package dmem_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef enum logic {OWN_CORE, OWN_LOADER} owner_t;

  // Lock counter must hold values up to and including lock_max.
  function automatic int unsigned lock_cnt_w(input int unsigned lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin pick between core and loader; loader owns the port while locked.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic   c_req,
  input  logic   l_req,
  input  owner_t last_winner,
  input  logic   locked,
  output logic   c_gnt,
  output logic   l_gnt
);

  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (locked) begin
      l_gnt = l_req;
    end else if (c_req && l_req) begin
      // Tie goes to whoever did not win last.
      if (last_winner == OWN_CORE) l_gnt = 1'b1;
      else                         c_gnt = 1'b1;
    end else begin
      c_gnt = c_req;
      l_gnt = l_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core and the program/debug loader,
// with a bounded loader lock for bursts and registered read-return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned CNT_W = lock_cnt_w(LOCK_MAX);

  arb_state_t       state_q, state_d;
  owner_t           last_q, last_d;
  owner_t           rd_owner_q;
  logic             rd_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_c, pick_l;

  dmem_rr_pick u_pick (
    .c_req       (c_req),
    .l_req       (l_req),
    .last_winner (last_q),
    .locked      (state_q == LOCKED),
    .c_gnt       (pick_c),
    .l_gnt       (pick_l)
  );

  // No access can be granted while the arbiter is held in reset.
  assign c_gnt   = pick_c & reset;
  assign l_gnt   = pick_l & reset;
  assign c_stall = c_req & ~c_gnt;

  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (c_gnt) begin
      mem_wr      = c_we;
      mem_rd      = ~c_we;
      mem_addr    = c_addr;
      mem_wr_data = c_wdata;
    end else if (l_gnt) begin
      mem_wr      = l_we;
      mem_rd      = ~l_we;
      mem_addr    = l_addr;
      mem_wr_data = l_wdata;
    end
  end

  // Next-state logic; a lock of one grant never needs the LOCKED state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (c_gnt)      last_d = OWN_CORE;
    else if (l_gnt) last_d = OWN_LOADER;
    case (state_q)
      ARB: begin
        if (l_gnt && l_lock && (LOCK_MAX > 32'd1)) begin
          state_d = LOCKED;
          cnt_d   = CNT_W'(1);
        end
      end
      LOCKED: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(LOCK_MAX - 1)) begin
          state_d = ARB;
          last_d  = OWN_LOADER;
        end else if (!l_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      last_q  <= OWN_LOADER;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Remember who issued the read so next cycle's memory data goes back to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_valid_q <= mem_rd;
      if (mem_rd) rd_owner_q <= c_gnt ? OWN_CORE : OWN_LOADER;
    end
  end

  assign c_rvalid = rd_valid_q & (rd_owner_q == OWN_CORE);
  assign l_rvalid = rd_valid_q & (rd_owner_q == OWN_LOADER);
  assign c_rdata  = c_rvalid ? mem_rd_data : '0;
  assign l_rdata  = l_rvalid ? mem_rd_data : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory behind the core's wr/rd/addr/wr_data/rd_data interface between two requesters: the riscv core (port c) and a program/debug loader (port l). The arbiter performs round-robin arbitration with a bounded loader lock for bursts. It returns synchronous read data to the owning port one cycle after the grant and produces a stall for the core. It sits between riscv and the data memory instance at top level.

Parameters:
DATA_W, 32, data width of all data buses
ADDR_W, 9, word address width (matches 9-bit addr)
LOCK_MAX, 16, max consecutive locked loader cycles before forced release (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
c_req  input  1  core access request
c_we  input  1  core write (1) / read (0)
c_addr  input  ADDR_W  core address
c_wdata  input  DATA_W  core write data
c_gnt  output  1  core granted this cycle
c_rvalid  output  1  core read data valid
c_rdata  output  DATA_W  core read data
c_stall  output  1  c_req & ~c_gnt
l_req  input  1  loader access request
l_we  input  1  loader write / read
l_addr  input  ADDR_W  loader address
l_wdata  input  DATA_W  loader write data
l_lock  input  1  loader requests to hold ownership after this grant
l_gnt  output  1  loader granted this cycle
l_rvalid  output  1  loader read data valid
l_rdata  output  DATA_W  loader read data
mem_wr  output  1  memory write strobe
mem_rd  output  1  memory read strobe
mem_addr  output  ADDR_W  memory address
mem_wr_data  output  DATA_W  memory write data
mem_rd_data  input  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset (reset=0, async): state=ARB, last_winner=LOADER, lock_cnt=0, rd_owner cleared, c_rvalid=l_rvalid=0. All gnt/mem strobes are forced 0 while reset is low. Any pending read return is dropped.
- Grant is combinational, in the same cycle as req. At most one gnt is high per cycle. A request is accepted exactly when its gnt=1; the requester holds req/addr/we/wdata stable until it sees gnt.
- State ARB:
  - If only one port requests, that port wins.
  - If both request, the port != last_winner wins. After reset, a tie goes to the core.
  - last_winner updates on every grant.
- ARB -> LOCKED when l_gnt=1 and l_lock=1. lock_cnt is loaded to 1.
- State LOCKED:
  - c_gnt=0 always. l_gnt=l_req.
  - lock_cnt increments on every LOCKED cycle.
  - LOCKED -> ARB on the next edge when l_lock=0, or when lock_cnt reaches LOCK_MAX (forced release).
  - On forced release, last_winner=LOADER, so a pending core request wins the next tie.
- Memory drive:
  - mem_rd = gnt & ~we and mem_wr = gnt & we of the winner.
  - mem_addr/mem_wr_data are muxed from the winner; both are 0 when nothing is granted.
- Read return:
  - rd_owner is registered on a read grant.
  - The next cycle, the owner's rvalid=1 and its rdata=mem_rd_data. The other port's rdata=0.
  - rvalid is a 1-cycle pulse. Back-to-back reads give back-to-back pulses.
  - A write grant produces no rvalid.
- Simultaneous events: a read return for one port and a new grant to the other port in the same cycle are independent and both allowed.
- No combinational path from mem_rd_data to any gnt.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum {ARB, LOCKED} arb_state_t
  - typedef enum {OWN_CORE, OWN_LOADER} owner_t
  - lock counter width derived as $clog2(LOCK_MAX+1)
- One combinational sub-module dmem_rr_pick: inputs c_req, l_req, last_winner, locked; outputs c_gnt, l_gnt.
- dmem_arbiter holds the FSM, counter, rd_owner and muxes.

Test Plan:
- Reset then core-only read: c_req=1, c_we=0, c_addr=9'h010, mem_rd_data=32'hDEADBEEF next cycle -> c_gnt=1, mem_rd=1, mem_addr=9'h010 same cycle; c_rvalid=1 and c_rdata=32'hDEADBEEF next cycle; l_rvalid=0.
- Both request every cycle, no lock, 4 cycles -> grants alternate core, loader, core, loader. c_stall=1 on the loader cycles.
- Loader write burst: l_lock=1 for 3 grants (addr 0,1,2, data 1,2,3) with c_req held high -> l_gnt 3 consecutive cycles, c_gnt=0 throughout, mem_wr=1 with matching addr/data. Core is granted the cycle after l_lock drops.
- Forced release: LOCK_MAX=4, l_lock and l_req held high, c_req high -> loader granted exactly 4 cycles, then core granted, then alternation.
- Reset asserted the cycle after a loader read grant -> l_rvalid stays 0. After reset release, a tie goes to the core.
- Loader read granted in cycle N, core write granted in cycle N+1 -> l_rvalid=1 in N+1 alongside mem_wr=1 from the core. c_rvalid=0.
